// File: rtl/rx_browser_pkg.sv
// rx_browser_pkg: overwrite policy constants and modulo wrap helpers
package rx_browser_pkg;
  localparam int OVR_DROP = 0;
  localparam int OVR_REPLACE = 1;
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned m);
    return (v >= m - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction
  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned m);
    return (v == 32'd0) ? m - 32'd1 : v - 32'd1;
  endfunction
endpackage

// File: rtl/rx_char_store.sv
// rx_char_store: circular character buffer with overwrite policy and registered read port
module rx_char_store
  import rx_browser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 100,
  parameter int OVERWRITE = OVR_DROP,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              overflow
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_base, rd_addr;
  logic [AW:0] sum;
  logic do_write;
  assign full = count == DEPTH_C;
  assign do_write = wr_en && !clear && (!full || OVERWRITE == OVR_REPLACE);
  assign sum = {1'b0, rd_base} + {1'b0, rd_idx};
  assign rd_addr = AW'((sum >= DEPTH_C) ? sum - DEPTH_C : sum);
  always_ff @(posedge Clk_100M)
    if (do_write) mem[wr_ptr] <= wr_data;
  always_ff @(posedge Clk_100M) begin
    if (Reset || clear) begin
      wr_ptr <= '0;
      rd_base <= '0;
      count <= '0;
      overflow <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_write) wr_ptr <= AW'(wrap_inc(32'(wr_ptr), DEPTH));
      if (do_write && full) rd_base <= AW'(wrap_inc(32'(rd_base), DEPTH));
      if (do_write && !full) count <= count + (AW+1)'(1);
      if (wr_en && full && OVERWRITE == OVR_DROP) overflow <= 1'b1;
      rd_data <= (count == '0) ? '0 : mem[rd_addr];
    end
  end
endmodule

// File: rtl/rx_char_browser.sv
// rx_char_browser: UART byte capture into a circular buffer with button-driven LED browse cursor
module rx_char_browser
  import rx_browser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 100,
  parameter int OVERWRITE = OVR_DROP,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Rx_Data,
  input  logic              Rx_Ready,
  output logic              Rx_Ack,
  input  logic              Prev_Btn,
  input  logic              Next_Btn,
  input  logic              Clear,
  output logic [DATA_W-1:0] LEDs,
  output logic [AW:0]       Char_Count,
  output logic [AW-1:0]     Cur_Index,
  output logic              Full,
  output logic              Overflow
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;
  logic prev_q, next_q, prev_edge, next_edge, accept;
  logic [AW-1:0] cur_nxt;
  assign prev_edge = Prev_Btn && !prev_q;
  assign next_edge = Next_Btn && !next_q;
  assign Rx_Ack = state == ACK;
  always_ff @(posedge Clk_100M) begin
    prev_q <= Prev_Btn;
    next_q <= Next_Btn;
    if (Reset) begin
      state <= IDLE;
      Cur_Index <= '0;
    end else begin
      state <= state_nxt;
      Cur_Index <= cur_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    accept = 1'b0;
    cur_nxt = Cur_Index;
    if (state == IDLE && Rx_Ready) begin
      state_nxt = ACK;
      accept = 1'b1;
    end
    if (state == ACK && !Rx_Ready) state_nxt = IDLE;
    if (Clear || Char_Count == '0) cur_nxt = '0;
    else if (prev_edge && !next_edge) cur_nxt = AW'(wrap_dec(32'(Cur_Index), 32'(Char_Count)));
    else if (next_edge && !prev_edge) cur_nxt = AW'(wrap_inc(32'(Cur_Index), 32'(Char_Count)));
  end
  rx_char_store #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_store (
    .Clk_100M(Clk_100M),
    .Reset(Reset),
    .clear(Clear),
    .wr_en(accept),
    .wr_data(Rx_Data),
    .rd_idx(Cur_Index),
    .rd_data(LEDs),
    .count(Char_Count),
    .full(Full),
    .overflow(Overflow)
  );
endmodule

// File: tb/tb_rx_char_browser.sv
// tb_rx_char_browser: directed, table-driven checks of capture, browse, overflow policy and clear
module tb_rx_char_browser;
  logic clk, Reset, Rx_Ready, Prev_Btn, Next_Btn, Clear;
  logic [7:0] Rx_Data;
  logic ack0, ack1, ack2, full0, full1, full2, ovf0, ovf1, ovf2;
  logic [7:0] leds0, leds1, leds2;
  logic [2:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic [1:0] idx0, idx1;
  logic [6:0] idx2;
  int checks = 0, errors = 0;

  typedef struct { logic p; logic n; int idx; int leds; } vec_t;
  vec_t v [8];

  rx_char_browser #(.DATA_W(8), .DEPTH(4), .OVERWRITE(0)) u0 (
    .Clk_100M(clk), .Reset(Reset), .Rx_Data(Rx_Data), .Rx_Ready(Rx_Ready), .Rx_Ack(ack0),
    .Prev_Btn(Prev_Btn), .Next_Btn(Next_Btn), .Clear(Clear), .LEDs(leds0),
    .Char_Count(cnt0), .Cur_Index(idx0), .Full(full0), .Overflow(ovf0));
  rx_char_browser #(.DATA_W(8), .DEPTH(4), .OVERWRITE(1)) u1 (
    .Clk_100M(clk), .Reset(Reset), .Rx_Data(Rx_Data), .Rx_Ready(Rx_Ready), .Rx_Ack(ack1),
    .Prev_Btn(Prev_Btn), .Next_Btn(Next_Btn), .Clear(Clear), .LEDs(leds1),
    .Char_Count(cnt1), .Cur_Index(idx1), .Full(full1), .Overflow(ovf1));
  rx_char_browser #(.DATA_W(8), .DEPTH(100), .OVERWRITE(0)) u2 (
    .Clk_100M(clk), .Reset(Reset), .Rx_Data(Rx_Data), .Rx_Ready(Rx_Ready), .Rx_Ack(ack2),
    .Prev_Btn(Prev_Btn), .Next_Btn(Next_Btn), .Clear(Clear), .LEDs(leds2),
    .Char_Count(cnt2), .Cur_Index(idx2), .Full(full2), .Overflow(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (ack0 !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", int'(ack0), int'(lvl));
  endtask

  task automatic send(input logic [7:0] b);
    Rx_Data = b;
    Rx_Ready = 1'b1;
    wait_ack(1'b1);
    Rx_Ready = 1'b0;
    wait_ack(1'b0);
    @(negedge clk);
  endtask

  task automatic pulse(input logic p, input logic n);
    Prev_Btn = p;
    Next_Btn = n;
    @(negedge clk);
    Prev_Btn = 1'b0;
    Next_Btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rises;
    logic last;
    v[0] = '{1'b0, 1'b1, 1, 8'h42};
    v[1] = '{1'b0, 1'b1, 2, 8'h43};
    v[2] = '{1'b0, 1'b1, 0, 8'h41};
    v[3] = '{1'b1, 1'b0, 2, 8'h43};
    v[4] = '{1'b1, 1'b1, 2, 8'h43};
    v[5] = '{1'b1, 1'b0, 1, 8'h42};
    v[6] = '{1'b1, 1'b0, 0, 8'h41};
    v[7] = '{1'b1, 1'b0, 2, 8'h43};
    Reset = 1'b0; Rx_Ready = 1'b0; Prev_Btn = 1'b0; Next_Btn = 1'b0; Clear = 1'b0; Rx_Data = '0;
    do_reset();
    chk("rst_ack", int'(ack0), 0);
    chk("rst_leds", int'(leds0), 0);
    chk("rst_count", int'(cnt0), 0);
    chk("rst_idx", int'(idx0), 0);
    chk("rst_full", int'(full0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    chk("rst_count100", int'(cnt2), 0);

    Rx_Data = 8'h41; Rx_Ready = 1'b1;
    @(negedge clk);
    chk("t1_ack_rise", int'(ack0), 1);
    chk("t1_count", int'(cnt0), 1);
    chk("t1_leds_latency", int'(leds0), 0);
    @(negedge clk);
    chk("t1_leds", int'(leds0), 8'h41);
    repeat (8) @(negedge clk);
    chk("t1_one_write", int'(cnt0), 1);
    chk("t1_ack_held", int'(ack0), 1);
    Rx_Ready = 1'b0;
    chk("t1_ack_before_fall", int'(ack0), 1);
    @(negedge clk);
    chk("t1_ack_fall", int'(ack0), 0);

    do_reset();
    send(8'h41); send(8'h42); send(8'h43);
    chk("t2_count", int'(cnt0), 3);
    chk("t2_leds0", int'(leds0), 8'h41);
    for (int i = 0; i < 8; i++) begin
      pulse(v[i].p, v[i].n);
      chk($sformatf("t2_idx_%0d", i), int'(idx0), v[i].idx);
      chk($sformatf("t2_leds_%0d", i), int'(leds0), v[i].leds);
      chk($sformatf("t2_leds_ovr_%0d", i), int'(leds1), v[i].leds);
    end

    do_reset();
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    chk("t3_full", int'(full0), 1);
    chk("t3_count", int'(cnt0), 4);
    chk("t3_ovf", int'(ovf0), 1);
    chk("t4_full", int'(full1), 1);
    chk("t4_count", int'(cnt1), 4);
    chk("t4_ovf", int'(ovf1), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t34_idx_%0d", k), int'(idx0), k);
      chk($sformatf("t3_leds_%0d", k), int'(leds0), 8'h31 + k);
      chk($sformatf("t4_leds_%0d", k), int'(leds1), 8'h32 + k);
      pulse(1'b0, 1'b1);
    end
    pulse(1'b1, 1'b0);
    chk("t34_idx_wrap", int'(idx0), 3);

    Clear = 1'b1; Next_Btn = 1'b1;
    @(negedge clk);
    Clear = 1'b0; Next_Btn = 1'b0;
    chk("clr_count", int'(cnt0), 0);
    chk("clr_idx", int'(idx0), 0);
    chk("clr_ovf", int'(ovf0), 0);
    chk("clr_full", int'(full0), 0);
    chk("clr_leds", int'(leds0), 0);
    pulse(1'b0, 1'b1);
    chk("t5_empty_next_idx", int'(idx0), 0);
    chk("t5_empty_next_leds", int'(leds0), 0);
    pulse(1'b1, 1'b0);
    chk("t5_empty_prev_idx", int'(idx0), 0);

    Rx_Data = 8'h77; Rx_Ready = 1'b1;
    @(negedge clk);
    chk("mid_acc_count", int'(cnt0), 1);
    Reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", int'(ack0), 0);
    chk("mid_rst_count", int'(cnt0), 0);
    Reset = 1'b0;
    @(negedge clk);
    chk("mid_reaccept_ack", int'(ack0), 1);
    chk("mid_reaccept_count", int'(cnt0), 1);
    @(negedge clk);
    chk("mid_reaccept_leds", int'(leds0), 8'h77);
    Rx_Ready = 1'b0;
    wait_ack(1'b0);

    do_reset();
    for (int i = 0; i < 100; i++) send(8'(i + 1));
    chk("t6_count", int'(cnt2), 100);
    chk("t6_full", int'(full2), 1);
    chk("t6_leds", int'(leds2), 8'h01);
    Rx_Data = 8'hAA; Rx_Ready = 1'b1; Clear = 1'b1;
    last = ack2;
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        Clear = 1'b0;
        chk("t6_clr_ack", int'(ack2), 1);
        chk("t6_clr_count", int'(cnt2), 0);
        chk("t6_clr_leds", int'(leds2), 0);
      end
      if (i == 2) Rx_Ready = 1'b0;
      if (ack2 && !last) rises++;
      last = ack2;
    end
    chk("t6_ack_once", rises, 1);
    chk("t6_ack_low", int'(ack2), 0);
    chk("t6_count_after", int'(cnt2), 0);
    chk("t6_ovf", int'(ovf2), 0);
    chk("t6_leds_after", int'(leds2), 0);
    send(8'h5A);
    chk("t6_new_count", int'(cnt2), 1);
    chk("t6_new_leds", int'(leds2), 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
